sisc_fetch: RTL

Instruction fetch unit for the SISC processor: it produces the 32-bit instruction word `ir` that the `sisc` core consumes. It holds the program counter and issues word reads to instruction memory over a request/acknowledge handshake. It presents each fetched word to the core with a valid/ready handshake and accepts branch redirects from the core's control unit. It sits between the instruction memory and the `ir` input of `sisc`.

---
 rtl/sisc_pkg.sv | 35 +++
 rtl/sisc_fetch_buf.sv | 51 +++++
 rtl/sisc_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// -----------------------------------------------------------------------------
// sisc_pkg
// Definitions shared by the SISC fetch unit and the SISC control unit:
//   - fetch_state_e : fetch unit states (IDLE, FETCH, FULL, SQUASH)
//   - SISC_ADDR_W / SISC_RESET_PC : default instruction address width and
//     the first fetch address after reset
//   - instruction field positions (opcode [31:28], mm [27:24]) plus small
//     helpers that extract them from an instruction word
// -----------------------------------------------------------------------------
package sisc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FULL   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_e;

    localparam int unsigned SISC_ADDR_W   = 16;
    localparam int unsigned SISC_RESET_PC = 0;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned MM_MSB     = 27;
    localparam int unsigned MM_LSB     = 24;

    function automatic logic [3:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [3:0] mm_of(input logic [31:0] word);
        return word[MM_MSB:MM_LSB];
    endfunction

endpackage

// File: rtl/sisc_fetch_buf.sv
// -----------------------------------------------------------------------------
// sisc_fetch_buf
// One-entry prefetch buffer for sisc_fetch. Parks a word fetched ahead of the
// core together with the address it came from. Only instantiated when the
// fetch unit is built with SISC_FETCH_PREFETCH_EN.
//
// Ports:
//   clk, rst_f        clock, synchronous active-high reset
//   load              capture load_data/load_addr (only used while empty)
//   load_data         fetched instruction word
//   load_addr         word address of load_data
//   pop               entry handed to the core this edge
//   flush             redirect: discard the entry (wins over load)
//   valid             entry is live
//   data, addr        parked word and its address
// -----------------------------------------------------------------------------
module sisc_fetch_buf
    import sisc_pkg::*;
#(
    parameter int unsigned ADDR_W = SISC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              load,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              pop,
    input  logic              flush,
    output logic              valid,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk) begin
        if (rst_f || flush || pop) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the payload needs no reset; nothing reads it unless valid is set,
    // so only the valid bit is cleared.
    always_ff @(posedge clk) begin
        if (load && !flush) begin
            data <= load_data;
            addr <= load_addr;
        end
    end

endmodule

// File: rtl/sisc_fetch.sv
// -----------------------------------------------------------------------------
// sisc_fetch
// Instruction fetch unit for the SISC core. Holds the fetch address, reads
// instruction memory over a req/ack handshake, presents each word to the core
// on ir/ir_valid/ir_ready and accepts taken-branch redirects (pc_write).
//
// Build option: SISC_FETCH_PREFETCH_EN adds a one-entry prefetch buffer
// (sisc_fetch_buf) so the next word is fetched while the core holds ir,
// giving one instruction per cycle with zero-wait memory. Without it no
// request is issued while an instruction is waiting in ir.
//
// Ports:
//   clk, rst_f        clock, synchronous active-high reset
//   imem_req          read request, held with a stable imem_addr until ack
//   imem_addr         word address being read (the fetch address)
//   imem_ack          read complete; imem_rdata valid this cycle
//   imem_rdata        instruction word from memory
//   ir, ir_valid      instruction to the core and its valid flag
//   ir_ready          core consumes ir at this edge when ir_valid is high
//   pc                address of the instruction in ir
//   pc_write          redirect request; wins over every event except IDLE
//   pc_target         redirect address
// -----------------------------------------------------------------------------
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = SISC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(SISC_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] pc_target
);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_inc;
    logic [31:0]       ir_next;
    logic              ir_valid_next;
    logic [ADDR_W-1:0] pc_next;
    // Redirect target remembered while a squashed request drains.
    logic [ADDR_W-1:0] target, target_next;

    assign addr_inc = imem_addr + ADDR_W'(1);

`ifdef SISC_FETCH_PREFETCH_EN
    logic              buf_load;
    logic              buf_pop;
    logic              buf_flush;
    logic              buf_valid;
    logic [31:0]       buf_data;
    logic [ADDR_W-1:0] buf_addr;

    sisc_fetch_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .rst_f     (rst_f),
        .load      (buf_load),
        .load_data (imem_rdata),
        .load_addr (imem_addr),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .valid     (buf_valid),
        .data      (buf_data),
        .addr      (buf_addr)
    );
`endif

    // NOTE: state registers take non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state     <= IDLE;
            imem_addr <= RESET_PC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            pc        <= RESET_PC;
            target    <= RESET_PC;
        end else begin
            state     <= state_next;
            imem_addr <= addr_next;
            ir        <= ir_next;
            ir_valid  <= ir_valid_next;
            pc        <= pc_next;
            target    <= target_next;
        end
    end

    // NOTE: every signal written here gets a hold/idle default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        addr_next     = imem_addr;
        ir_next       = ir;
        ir_valid_next = ir_valid;
        pc_next       = pc;
        target_next   = target;
        imem_req      = 1'b0;
`ifdef SISC_FETCH_PREFETCH_EN
        buf_load      = 1'b0;
        buf_pop       = 1'b0;
        buf_flush     = 1'b0;
`endif

        case (state)
            IDLE: begin
                // pc_write is deliberately ignored for this single cycle.
                state_next = FETCH;
                addr_next  = RESET_PC;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (pc_write) begin
                    if (imem_ack) begin
                        // Data of the old address is dropped; new request
                        // starts next cycle.
                        addr_next = pc_target;
                    end else begin
                        // Request must finish at its original address.
                        target_next = pc_target;
                        state_next  = SQUASH;
                    end
                end else if (imem_ack) begin
                    ir_next       = imem_rdata;
                    pc_next       = imem_addr;
                    ir_valid_next = 1'b1;
                    addr_next     = addr_inc;
                    state_next    = FULL;
                end
            end

            SQUASH: begin
                imem_req = 1'b1;
                if (pc_write) begin
                    target_next = pc_target;
                end
                if (imem_ack) begin
                    addr_next  = pc_write ? pc_target : target;
                    state_next = FETCH;
                end
            end

            FULL: begin
`ifdef SISC_FETCH_PREFETCH_EN
                // Fetch ahead whenever the buffer has room.
                imem_req = !buf_valid;
                if (pc_write) begin
                    ir_valid_next = 1'b0;
                    buf_flush     = 1'b1;
                    if (!buf_valid && !imem_ack) begin
                        // Prefetch in flight: let it drain, then redirect.
                        target_next = pc_target;
                        state_next  = SQUASH;
                    end else begin
                        addr_next  = pc_target;
                        state_next = FETCH;
                    end
                end else if (ir_ready) begin
                    if (buf_valid) begin
                        ir_next = buf_data;
                        pc_next = buf_addr;
                        buf_pop = 1'b1;
                    end else if (imem_ack) begin
                        // Word arrives as the core consumes: bypass the buffer.
                        ir_next   = imem_rdata;
                        pc_next   = imem_addr;
                        addr_next = addr_inc;
                    end else begin
                        // Nothing to hand over; keep the request going in FETCH.
                        ir_valid_next = 1'b0;
                        state_next    = FETCH;
                    end
                end else if (!buf_valid && imem_ack) begin
                    buf_load  = 1'b1;
                    addr_next = addr_inc;
                end
`else
                if (pc_write) begin
                    ir_valid_next = 1'b0;
                    addr_next     = pc_target;
                    state_next    = FETCH;
                end else if (ir_ready) begin
                    ir_valid_next = 1'b0;
                    state_next    = FETCH;
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
